stream_guard: RTL and testbench
===============================

# stream_guard

Downstream consumer stage for the elastic register chain. It takes the chain's output valid/ready stream into a DEPTH-entry FIFO and presents it again on a master valid/ready port. A watchdog raises a sticky alarm when upstream withholds valid for TIMEOUT consecutive cycles while traffic is expected, which is the signature of a data-suppressing insertion. It also counts delivered words.

## Interface
- DW, 16: data width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TIMEOUT, 64: starvation cycles before alarm; ≥2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data_i  in  DW  upstream data.
- s_valid_i  in  1  upstream valid.
- s_ready_o  out  1  upstream ready.
- m_data_o  out  DW  output data.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  output ready.
- expect_i  in  1  traffic expected; the integration ties it to the chain's external input valid.
- clr_i  in  1  synchronous clear of alarm, watchdog and counters.
- alarm_o  out  1  sticky starvation alarm.
- xfer_cnt_o  out  16  count of output transfers.
- csum_o  out  DW  running XOR checksum of accepted words.

## Operation
- Push: s_fire = s_valid_i && s_ready_o; s_ready_o = !full.
- Pop: m_fire = m_valid_o && m_ready_i; m_valid_o = !empty; m_data_o = entry at the read pointer (first-word fall-through from the array).
- Occupancy counter is $clog2(DEPTH)+1 bits wide. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. When full, no push is accepted, even if a pop occurs in the same cycle.
- Watchdog: starve = expect_i && !s_valid_i. FSM IDLE/WAIT/ALARM with counter wd_cnt ($clog2(TIMEOUT+1) bits).
  - IDLE: if starve, go to WAIT with wd_cnt ← 1.
  - WAIT: if !starve, go to IDLE with wd_cnt ← 0. Else if wd_cnt == TIMEOUT-1, go to ALARM. Else wd_cnt++.
  - ALARM: stays until clr_i, then goes to IDLE with wd_cnt ← 0.
- alarm_o = (state == ALARM). The alarm never blocks the data path.
- xfer_cnt_o increments on m_fire and wraps 0xFFFF → 0.
- clr_i: FSM ← IDLE, wd_cnt ← 0, xfer_cnt_o ← 0, csum_o ← 0. clr_i wins over any same-cycle increment, transition or fold. FIFO contents and pointers are untouched.

## Timing
- Reset values: s_ready_o=1, m_valid_o=0, m_data_o=0, alarm_o=0, xfer_cnt_o=0, csum_o=0. FIFO is empty and FSM is IDLE.
- Latency: a word pushed at edge N is visible on m_valid_o/m_data_o after edge N when the FIFO was empty. There is no same-cycle pass-through.
- m_data_o stays stable while m_valid_o && !m_ready_i.
- Alarm: with starve high for cycles 1..TIMEOUT, alarm_o rises after the edge ending cycle TIMEOUT. With starve high for TIMEOUT-1 cycles and then low, no alarm.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Data in flight is lost.

## Configuration
- STREAM_GUARD_CSUM_EN defined: csum_o ← csum_o ^ s_data_i on each s_fire.
- Not defined: csum_o is constant 0 and no checksum register is built.

## Test plan
- Pass-through: push 0x1111, 0x2222, 0x3333 with m_ready_i=1 → same order out, each 1 cycle after push; xfer_cnt_o=3.
- Full/backpressure: m_ready_i=0, push 5 words with DEPTH=4 → s_ready_o=0 after the 4th. The 5th is held upstream and delivered after m_ready_i=1; order is preserved.
- Watchdog: TIMEOUT=8, expect_i=1, s_valid_i=0 for 7 cycles, then valid → alarm_o stays 0. Then 8 starve cycles → alarm_o=1, holding through later traffic until clr_i. One cycle after clr_i, alarm_o=0.
- Counter wrap and clr: 65537 transfers → xfer_cnt_o=1. clr_i asserted during a transfer → xfer_cnt_o=0.
- Checksum with STREAM_GUARD_CSUM_EN: push 0x00FF, 0x0F0F → csum_o=0x0FF0. Without the macro, csum_o=0 throughout.
- Async reset: assert rst between edges with 2 words queued → m_valid_o drops immediately and s_ready_o=1.

Source files
------------

// File: rtl/stream_guard.sv
// stream_guard: consumer stage for the elastic register chain.
// Buffers the incoming valid/ready stream in a DEPTH-entry first-word
// fall-through FIFO and re-presents it on a master valid/ready port.
// A watchdog raises a sticky alarm when upstream withholds valid for
// TIMEOUT consecutive cycles while traffic is expected. It also counts
// delivered words.
// Optional feature: define STREAM_GUARD_CSUM_EN to build a running XOR
// checksum of accepted words on csum_o; otherwise csum_o is tied to 0.
module stream_guard #(
    parameter int DW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    input  logic          expect_i,
    input  logic          clr_i,
    output logic          alarm_o,
    output logic [15:0]   xfer_cnt_o,
    output logic [DW-1:0] csum_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ALARM = 2'd2
    } wd_state_t;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          s_fire;
    logic          m_fire;
    logic          starve;
    wd_state_t     state;
    logic [WW-1:0] wd_cnt;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // A full FIFO refuses pushes even when a pop frees a slot this cycle,
    // which keeps ready independent of the downstream ready.
    assign s_ready_o = !full;
    assign m_valid_o = !empty;
    assign m_data_o  = mem[rd_ptr];
    assign s_fire    = s_valid_i && s_ready_o;
    assign m_fire    = m_valid_o && m_ready_i;
    assign starve    = expect_i && !s_valid_i;
    assign alarm_o   = (state == ST_ALARM);

    // Storage array; cleared on reset so m_data_o reads 0 while empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (s_fire) begin
            mem[wr_ptr] <= s_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (s_fire) wr_ptr <= wr_ptr + AW'(1);
            if (m_fire) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({s_fire, m_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation watchdog; clr_i overrides every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
        end else if (clr_i) begin
            state  <= ST_IDLE;
            wd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (starve) begin
                        state  <= ST_WAIT;
                        wd_cnt <= WW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!starve) begin
                        state  <= ST_IDLE;
                        wd_cnt <= '0;
                    end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                        state <= ST_ALARM;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                ST_ALARM: begin
                    state <= ST_ALARM;
                end
                default: begin
                    state  <= ST_IDLE;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

    // Delivered-word counter, wraps at 16 bits; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_o <= '0;
        end else if (clr_i) begin
            xfer_cnt_o <= '0;
        end else if (m_fire) begin
            xfer_cnt_o <= xfer_cnt_o + 16'd1;
        end
    end

`ifdef STREAM_GUARD_CSUM_EN
    // Running XOR of every accepted word; clear wins over the fold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_o <= '0;
        end else if (clr_i) begin
            csum_o <= '0;
        end else if (s_fire) begin
            csum_o <= csum_o ^ s_data_i;
        end
    end
`else
    assign csum_o = '0;
`endif

endmodule

// File: tb/tb_stream_guard.sv
// Scoreboard bench for stream_guard: stimulus pushes expected words into a
// queue, a monitor pops and compares on every output transfer.
module tb_stream_guard;

    localparam int DW      = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          expect_i;
    logic          clr_i;
    logic          alarm_o;
    logic [15:0]   xfer_cnt_o;
    logic [DW-1:0] csum_o;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_csum = '0;

    stream_guard #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .expect_i(expect_i), .clr_i(clr_i), .alarm_o(alarm_o),
        .xfer_cnt_o(xfer_cnt_o), .csum_o(csum_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && m_valid_o && m_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got %0h expected nothing", m_data_o);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_data_o !== e) begin
                    miscompares++;
                    $display("FAIL out_data: got %0h expected %0h", m_data_o, e);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        exp_q.push_back(d);
`ifdef STREAM_GUARD_CSUM_EN
        exp_csum = exp_csum ^ d;
`endif
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_data_i  = d;
        s_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready_o) break;
            n++;
            if (n > 200) begin
                check("push_timeout", 32'(s_ready_o), 32'd1);
                s_valid_i = 1'b0;
                return;
            end
        end
        model_accept(d);
        cycle();
        s_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_valid_o && n < 100) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(m_valid_o), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear();
        clr_i = 1'b1;
        cycle();
        clr_i = 1'b0;
        exp_csum = '0;
    endtask

    initial begin
        int n;
        logic acc;
        rst = 1'b1;
        s_data_i = '0; s_valid_i = 1'b0; m_ready_i = 1'b0;
        expect_i = 1'b0; clr_i = 1'b0;
        #12;
        check("rst_s_ready", 32'(s_ready_o), 32'd1);
        check("rst_m_valid", 32'(m_valid_o), 32'd0);
        check("rst_m_data", 32'(m_data_o), 32'd0);
        check("rst_alarm", 32'(alarm_o), 32'd0);
        check("rst_xfer", 32'(xfer_cnt_o), 32'd0);
        check("rst_csum", 32'(csum_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();

        // Pass-through: each word visible right after its push edge.
        m_ready_i = 1'b1;
        push(16'h1111);
        check("pt_valid1", 32'(m_valid_o), 32'd1);
        check("pt_data1", 32'(m_data_o), 32'h1111);
        push(16'h2222);
        check("pt_data2", 32'(m_data_o), 32'h2222);
        push(16'h3333);
        check("pt_data3", 32'(m_data_o), 32'h3333);
        cycle();
        check("pt_xfer", 32'(xfer_cnt_o), 32'd3);
        check("pt_empty", 32'(m_valid_o), 32'd0);

        // Full and backpressure: 5th word waits upstream.
        m_ready_i = 1'b0;
        push(16'hA001);
        push(16'hA002);
        push(16'hA003);
        check("full_ready3", 32'(s_ready_o), 32'd1);
        push(16'hA004);
        check("full_ready4", 32'(s_ready_o), 32'd0);
        s_data_i = 16'hA005; s_valid_i = 1'b1;
        repeat (3) cycle();
        check("full_hold_ready", 32'(s_ready_o), 32'd0);
        check("full_stable_data", 32'(m_data_o), 32'hA001);
        m_ready_i = 1'b1;
        push(16'hA005);
        drain();
        check("full_xfer", 32'(xfer_cnt_o), 32'd8);
        check("csum_run", 32'(csum_o), 32'(exp_csum));

        // Checksum after a clear.
        clear();
        check("clr_xfer", 32'(xfer_cnt_o), 32'd0);
        check("clr_csum", 32'(csum_o), 32'd0);
        push(16'h00FF);
        push(16'h0F0F);
        drain();
`ifdef STREAM_GUARD_CSUM_EN
        check("csum_pair", 32'(csum_o), 32'h0FF0);
`else
        check("csum_pair", 32'(csum_o), 32'h0000);
`endif
        check("csum_xfer", 32'(xfer_cnt_o), 32'd2);

        // Watchdog: TIMEOUT-1 starve cycles, then valid -> no alarm.
        expect_i = 1'b1;
        repeat (TIMEOUT - 1) cycle();
        check("wd_short", 32'(alarm_o), 32'd0);
        push(16'hB001);
        check("wd_short_after", 32'(alarm_o), 32'd0);
        repeat (TIMEOUT - 1) cycle();
        check("wd_almost", 32'(alarm_o), 32'd0);
        cycle();
        check("wd_alarm", 32'(alarm_o), 32'd1);
        push(16'hB002);
        push(16'hB003);
        drain();
        check("wd_sticky", 32'(alarm_o), 32'd1);
        expect_i = 1'b0;
        clear();
        check("wd_cleared", 32'(alarm_o), 32'd0);
        cycle();
        check("wd_cleared2", 32'(alarm_o), 32'd0);

        // Clear during an output transfer: clear wins, word still delivered.
        m_ready_i = 1'b0;
        push(16'hC001);
        m_ready_i = 1'b1;
        clear();
        check("clr_fire_xfer", 32'(xfer_cnt_o), 32'd0);
        check("clr_fire_empty", 32'(m_valid_o), 32'd0);
        check("clr_fire_csum", 32'(csum_o), 32'd0);

        // Counter wrap: 65537 transfers -> 1.
        n = 0;
        s_data_i  = '0;
        s_valid_i = 1'b1;
        while (n < 65537) begin
            @(negedge clk);
            acc = s_ready_o;
            if (acc) begin
                model_accept(n[15:0]);
                n++;
            end
            cycle();
            if (acc) s_data_i = n[15:0];
        end
        s_valid_i = 1'b0;
        drain();
        check("wrap_xfer", 32'(xfer_cnt_o), 32'd1);
        check("wrap_csum", 32'(csum_o), 32'(exp_csum));

        // Async reset between edges with two words queued.
        m_ready_i = 1'b0;
        push(16'hD001);
        push(16'hD002);
        check("ar_before", 32'(m_valid_o), 32'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(m_valid_o), 32'd0);
        check("ar_ready", 32'(s_ready_o), 32'd1);
        check("ar_data", 32'(m_data_o), 32'd0);
        check("ar_xfer", 32'(xfer_cnt_o), 32'd0);
        exp_q.delete();
        exp_csum = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        check("ar_after", 32'(m_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
